// File: rtl/rf_wb_arbiter.sv
// Writeback arbiter: round-robin between ALU and LSU onto the register-file write port,
// plus a pending-write scoreboard that stalls decode on busy source registers.
module rf_wb_arbiter (
    input  logic        clk,
    input  logic        srst,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    output logic        alu_ready,
    input  logic        lsu_valid,
    input  logic [4:0]  lsu_rd,
    input  logic [31:0] lsu_data,
    output logic        lsu_ready,
    input  logic        iss_valid,
    input  logic [4:0]  iss_rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    output logic        stall,
    output logic [31:0] busy,
    output logic        WE3,
    output logic [4:0]  A3,
    output logic [31:0] WD3
);
    localparam logic LG_ALU = 1'b0;
    localparam logic LG_LSU = 1'b1;

    logic        r_last_grant;
    logic [31:0] r_busy;
    logic        r_we3;
    logic [4:0]  r_a3;
    logic [31:0] r_wd3;

    logic        w_grant_alu;
    logic        w_grant_lsu;
    logic        w_grant;
    logic [4:0]  w_rd;
    logic [31:0] w_data;
    logic [31:0] w_busy_next;

    always_comb begin
        w_grant_alu = 1'b0;
        w_grant_lsu = 1'b0;
        if (!srst) begin
            if (alu_valid && lsu_valid) begin
                w_grant_alu = (r_last_grant == LG_LSU);
                w_grant_lsu = (r_last_grant == LG_ALU);
            end else begin
                w_grant_alu = alu_valid;
                w_grant_lsu = lsu_valid;
            end
        end
    end

    assign w_grant = w_grant_alu | w_grant_lsu;
    assign w_rd    = w_grant_lsu ? lsu_rd   : alu_rd;
    assign w_data  = w_grant_lsu ? lsu_data : alu_data;

    // Set after clear so a same-edge issue to the register being written back stays pending.
    always_comb begin
        w_busy_next = r_busy;
        if (w_grant && (w_rd != 5'd0)) w_busy_next[w_rd] = 1'b0;
        if (iss_valid && (iss_rd != 5'd0)) w_busy_next[iss_rd] = 1'b1;
        w_busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            r_last_grant <= LG_LSU;
            r_busy       <= 32'd0;
            r_we3        <= 1'b0;
            r_a3         <= 5'd0;
            r_wd3        <= 32'd0;
        end else begin
            r_busy <= w_busy_next;
            r_we3  <= w_grant && (w_rd != 5'd0);
            if (w_grant) begin
                r_last_grant <= w_grant_lsu ? LG_LSU : LG_ALU;
                r_a3         <= w_rd;
                r_wd3        <= w_data;
            end
        end
    end

    assign alu_ready = w_grant_alu;
    assign lsu_ready = w_grant_lsu;
    assign busy      = r_busy;
    assign stall     = r_busy[rs1] | r_busy[rs2];
    assign WE3       = r_we3;
    assign A3        = r_a3;
    assign WD3       = r_wd3;
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed scenarios plus randomized traffic, all checked cycle by cycle against
// a behavioural model of arbitration, scoreboard and writeback latency.
module tb_rf_wb_arbiter;
    logic        clk = 1'b0;
    logic        srst;
    logic        alu_valid, lsu_valid, iss_valid;
    logic [4:0]  alu_rd, lsu_rd, iss_rd, rs1, rs2;
    logic [31:0] alu_data, lsu_data;
    logic        alu_ready, lsu_ready, stall, WE3;
    logic [31:0] busy, WD3;
    logic [4:0]  A3;

    rf_wb_arbiter dut (
        .clk(clk), .srst(srst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .rs1(rs1), .rs2(rs2),
        .stall(stall), .busy(busy), .WE3(WE3), .A3(A3), .WD3(WD3)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: pending-register set, which port won most recently, and the write due next cycle.
    logic [31:0] m_busy;
    logic        m_last_lsu;
    logic        m_we;
    logic        m_zero;
    logic [4:0]  m_a3;
    logic [31:0] m_wd3;
    logic        e_ag, e_lg;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic predict();
        e_ag = 1'b0;
        e_lg = 1'b0;
        if (!srst) begin
            if (alu_valid && lsu_valid) begin
                if (m_last_lsu) e_ag = 1'b1;
                else            e_lg = 1'b1;
            end else begin
                e_ag = alu_valid;
                e_lg = lsu_valid;
            end
        end
    endtask

    task automatic sample();
        @(negedge clk);
        predict();
        chk("alu_ready", {31'd0, alu_ready}, {31'd0, e_ag});
        chk("lsu_ready", {31'd0, lsu_ready}, {31'd0, e_lg});
        chk("busy", busy, m_busy);
        chk("stall", {31'd0, stall}, {31'd0, m_busy[rs1] | m_busy[rs2]});
        chk("WE3", {31'd0, WE3}, {31'd0, m_we});
        if (m_we || m_zero) begin
            chk("A3", {27'd0, A3}, {27'd0, m_a3});
            chk("WD3", WD3, m_wd3);
        end
    endtask

    task automatic adv();
        logic [4:0]  rd;
        logic [31:0] d;
        logic [31:0] nb;
        @(posedge clk);
        if (srst) begin
            m_busy = 32'd0; m_we = 1'b0; m_a3 = 5'd0; m_wd3 = 32'd0;
            m_last_lsu = 1'b1; m_zero = 1'b1;
        end else begin
            nb = m_busy;
            m_we = 1'b0;
            if (e_ag || e_lg) begin
                rd = e_lg ? lsu_rd : alu_rd;
                d  = e_lg ? lsu_data : alu_data;
                m_zero = 1'b0;
                m_a3 = rd;
                m_wd3 = d;
                m_we = (rd != 5'd0);
                if (rd != 5'd0) nb[rd] = 1'b0;
                m_last_lsu = e_lg;
            end
            if (iss_valid && iss_rd != 5'd0) nb[iss_rd] = 1'b1;
            m_busy = nb;
        end
        #1;
    endtask

    task automatic step();
        sample();
        adv();
    endtask

    task automatic idle();
        alu_valid = 1'b0; lsu_valid = 1'b0; iss_valid = 1'b0;
        alu_rd = 5'd0; lsu_rd = 5'd0; iss_rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
        alu_data = 32'd0; lsu_data = 32'd0;
    endtask

    initial begin
        idle();
        srst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        m_busy = 32'd0; m_we = 1'b0; m_a3 = 5'd0; m_wd3 = 32'd0;
        m_last_lsu = 1'b1; m_zero = 1'b1;

        // Requests during reset are refused.
        alu_valid = 1'b1; lsu_valid = 1'b1; alu_rd = 5'd1; lsu_rd = 5'd2;
        sample();
        chk("rst_alu_ready", {31'd0, alu_ready}, 32'd0);
        chk("rst_outputs", {WE3, A3, 26'd0}, 32'd0);
        adv();
        srst = 1'b0;

        // First contention after reset goes to ALU, then LSU, one-cycle writeback latency.
        alu_rd = 5'd5; alu_data = 32'h1111_0005; lsu_rd = 5'd6; lsu_data = 32'h2222_0006;
        sample();
        chk("c0_alu_ready", {31'd0, alu_ready}, 32'd1);
        adv();
        alu_valid = 1'b0;
        sample();
        chk("c1_we3", {31'd0, WE3}, 32'd1);
        chk("c1_a3", {27'd0, A3}, 32'd5);
        chk("c1_lsu_ready", {31'd0, lsu_ready}, 32'd1);
        adv();
        lsu_valid = 1'b0;
        sample();
        chk("c2_a3", {27'd0, A3}, 32'd6);
        chk("c2_wd3", WD3, 32'h2222_0006);
        adv();

        // Continuous contention alternates, starting with ALU since LSU won last.
        alu_valid = 1'b1; lsu_valid = 1'b1; alu_rd = 5'd10; lsu_rd = 5'd11;
        for (int i = 0; i < 4; i++) begin
            sample();
            chk("rr_alu", {31'd0, alu_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("rr_lsu", {31'd0, lsu_ready}, (i % 2 == 1) ? 32'd1 : 32'd0);
            adv();
        end
        idle();
        step();

        // Issue to r7 stalls a reader until the LSU writes r7 back.
        iss_valid = 1'b1; iss_rd = 5'd7;
        step();
        iss_valid = 1'b0; rs1 = 5'd7;
        sample();
        chk("s_busy7", {31'd0, busy[7]}, 32'd1);
        chk("s_stall", {31'd0, stall}, 32'd1);
        adv();
        lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'h0000_0777;
        step();
        lsu_valid = 1'b0;
        sample();
        chk("s_busy7_clr", {31'd0, busy[7]}, 32'd0);
        chk("s_stall_clr", {31'd0, stall}, 32'd0);
        adv();

        // Same-edge issue and writeback to r9: the newer issue keeps it pending.
        iss_valid = 1'b1; iss_rd = 5'd9;
        step();
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h9;
        step();
        idle();
        sample();
        chk("same_edge_busy9", {31'd0, busy[9]}, 32'd1);
        adv();

        // Writes to x0 are accepted but never reach the register file.
        srst = 1'b1;
        step();
        srst = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hDEAD_BEEF;
        sample();
        chk("x0_ready", {31'd0, alu_ready}, 32'd1);
        adv();
        idle();
        sample();
        chk("x0_we3", {31'd0, WE3}, 32'd0);
        chk("x0_busy", busy, 32'd0);
        adv();

        // Reset right after acceptance discards the pending write and the scoreboard.
        iss_valid = 1'b1; iss_rd = 5'd12;
        step();
        iss_valid = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h3333_3333;
        step();
        alu_valid = 1'b0; srst = 1'b1; iss_valid = 1'b1; iss_rd = 5'd13;
        step();
        srst = 1'b0; iss_valid = 1'b0;
        sample();
        chk("rst_mid_we3", {31'd0, WE3}, 32'd0);
        chk("rst_mid_busy", busy, 32'd0);
        chk("rst_mid_a3_wd3", {27'd0, A3} | WD3, 32'd0);
        adv();

        // Randomized traffic; an ungranted request is held stable until granted.
        idle();
        for (int i = 0; i < 600; i++) begin
            if (!(alu_valid && !e_ag) || i == 0) begin
                alu_valid = ($urandom_range(0, 2) != 0);
                alu_rd    = 5'($urandom_range(0, 7));
                alu_data  = $urandom;
            end
            if (!(lsu_valid && !e_lg) || i == 0) begin
                lsu_valid = ($urandom_range(0, 2) != 0);
                lsu_rd    = 5'($urandom_range(0, 7));
                lsu_data  = $urandom;
            end
            iss_valid = ($urandom_range(0, 1) == 1);
            iss_rd    = 5'($urandom_range(0, 7));
            rs1       = 5'($urandom_range(0, 7));
            rs2       = 5'($urandom_range(0, 31));
            srst      = ($urandom_range(0, 49) == 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
